// File: rtl/registers_bank_sb.sv
// registers_bank_sb
//   Two-read / one-write register bank with a per-register pending-write
//   scoreboard for read-after-write hazard detection in decode.
//
// Parameters
//   DATA_WIDTH : register width
//   ADDR_WIDTH : address width, depth = 2**ADDR_WIDTH
//   ZERO_REG   : 1 -> register 0 is hardwired to zero and never pending
//   BYPASS     : 1 -> a read of the register being written returns `data`
//
// Ports
//   clk, rst           : clock, asynchronous active-high reset
//   en, rd, data       : writeback write port
//   rs, rt             : read addresses
//   data_rs, data_rt   : combinational read data
//   rsv_en, rsv_rd     : mark a destination register as pending
//   clr                : flush all pending bits
//   rs_busy, rt_busy   : combinational hazard flags for rs / rt
//   pend_cnt           : registered count of pending registers
//   rsv_err            : registered pulse, reservation hit a pending register
module registers_bank_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter bit ZERO_REG   = 1'b1,
    parameter bit BYPASS     = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] rd,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] rs,
    input  logic [ADDR_WIDTH-1:0] rt,
    output logic [DATA_WIDTH-1:0] data_rs,
    output logic [DATA_WIDTH-1:0] data_rt,
    input  logic                  rsv_en,
    input  logic [ADDR_WIDTH-1:0] rsv_rd,
    input  logic                  clr,
    output logic                  rs_busy,
    output logic                  rt_busy,
    output logic [ADDR_WIDTH:0]   pend_cnt,
    output logic                  rsv_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]      pend_q, pend_d;
    logic [ADDR_WIDTH:0]   pend_cnt_q, pend_cnt_d;
    logic                  rsv_err_q, rsv_err_d;

    logic wr_ok;      // write actually commits (not to the hardwired zero)
    logic rsv_ok;     // reservation actually takes effect
    logic same_addr;  // write and reservation target the same register
    logic set_inc;
    logic clr_dec;

    assign wr_ok     = en && !(ZERO_REG && (rd == '0));
    assign rsv_ok    = rsv_en && !(ZERO_REG && (rsv_rd == '0));
    assign same_addr = (rd == rsv_rd);

    // The reservation is applied after the write so a same-cycle producer
    // wins over the retiring one; a flush overrides both.
    always_comb begin
        pend_d = pend_q;
        if (wr_ok) begin
            pend_d[rd] = 1'b0;
        end
        if (rsv_ok) begin
            pend_d[rsv_rd] = 1'b1;
        end
        if (clr) begin
            pend_d = '0;
        end
    end

    // Incremental popcount: a same-address write+reserve leaves the bit set,
    // so the write's clear does not count in that case.
    assign set_inc = rsv_ok && !pend_q[rsv_rd];
    assign clr_dec = wr_ok && pend_q[rd] && !(rsv_ok && same_addr);

    always_comb begin
        if (clr) begin
            pend_cnt_d = '0;
        end else begin
            pend_cnt_d = pend_cnt_q + {{ADDR_WIDTH{1'b0}}, set_inc}
                                    - {{ADDR_WIDTH{1'b0}}, clr_dec};
        end
    end

    assign rsv_err_d = rsv_ok && pend_q[rsv_rd] && !(en && same_addr) && !clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            pend_q     <= '0;
            pend_cnt_q <= '0;
            rsv_err_q  <= 1'b0;
        end else begin
            if (wr_ok) begin
                regs_q[rd] <= data;
            end
            pend_q     <= pend_d;
            pend_cnt_q <= pend_cnt_d;
            rsv_err_q  <= rsv_err_d;
        end
    end

    // Read ports: identical logic replicated for rs and rt.
    logic [ADDR_WIDTH-1:0] port_addr [2];
    logic [DATA_WIDTH-1:0] port_data [2];
    logic                  port_busy [2];

    assign port_addr[0] = rs;
    assign port_addr[1] = rt;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_read
            logic is_zero;
            logic hit;
            assign is_zero = ZERO_REG && (port_addr[gi] == '0);
            // Bypass is held off during reset so outputs read zero then.
            assign hit     = BYPASS && wr_ok && !rst && (rd == port_addr[gi]);
            assign port_data[gi] = is_zero ? '0
                                 : hit     ? data
                                 :           regs_q[port_addr[gi]];
            assign port_busy[gi] = !is_zero && pend_q[port_addr[gi]] && !hit;
        end
    endgenerate

    assign data_rs  = port_data[0];
    assign data_rt  = port_data[1];
    assign rs_busy  = port_busy[0];
    assign rt_busy  = port_busy[1];
    assign pend_cnt = pend_cnt_q;
    assign rsv_err  = rsv_err_q;

endmodule

// File: tb/tb_registers_bank_sb.sv
module tb_registers_bank_sb;

    logic        clk = 1'b0;
    logic        rst, en, rsv_en, clr;
    logic [4:0]  rd, rs, rt, rsv_rd;
    logic [31:0] data;

    logic [31:0] d0_rs, d0_rt, d1_rs, d1_rt;
    logic        b0_rs, b0_rt, b1_rs, b1_rt, e0, e1;
    logic [5:0]  c0, c1;

    always #5 clk = ~clk;

    registers_bank_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .rd(rd), .data(data), .rs(rs), .rt(rt),
        .data_rs(d0_rs), .data_rt(d0_rt), .rsv_en(rsv_en), .rsv_rd(rsv_rd), .clr(clr),
        .rs_busy(b0_rs), .rt_busy(b0_rt), .pend_cnt(c0), .rsv_err(e0));

    registers_bank_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .rd(rd), .data(data), .rs(rs), .rt(rt),
        .data_rs(d1_rs), .data_rt(d1_rt), .rsv_en(rsv_en), .rsv_rd(rsv_rd), .clr(clr),
        .rs_busy(b1_rs), .rt_busy(b1_rt), .pend_cnt(c1), .rsv_err(e1));

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural reference: architectural state only.
    logic [31:0] m_regs [32];
    bit          m_pend [32];
    bit          m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'h0;
            m_pend[i] = 1'b0;
        end
        m_err = 1'b0;
    endtask

    // One rising edge of the architectural rules.
    task automatic model_edge();
        bit old_pend [32];
        if (rst) return;
        for (int i = 0; i < 32; i++) old_pend[i] = m_pend[i];
        m_err = 1'b0;
        if (en && rd != 0) begin
            m_regs[rd] = data;
            m_pend[rd] = 1'b0;
        end
        if (rsv_en && rsv_rd != 0) begin
            m_err = old_pend[rsv_rd] && !(en && rd == rsv_rd) && !clr;
            m_pend[rsv_rd] = 1'b1;
        end
        if (clr) begin
            for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        end
    endtask

    function automatic logic [31:0] exp_data(input logic [4:0] a, input bit byp);
        if (a == 0) return 32'h0;
        if (byp && en && !rst && rd == a) return data;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a, input bit byp);
        if (a == 0) return 1'b0;
        return m_pend[a] && !(byp && en && !rst && rd == a);
    endfunction

    function automatic logic [31:0] popcount();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_pend[i]);
        return 32'(n);
    endfunction

    task automatic check_all(input string tag);
        chk({tag, " b0 data_rs"}, d0_rs, exp_data(rs, 1'b0));
        chk({tag, " b0 data_rt"}, d0_rt, exp_data(rt, 1'b0));
        chk({tag, " b0 rs_busy"}, {31'b0, b0_rs}, {31'b0, exp_busy(rs, 1'b0)});
        chk({tag, " b0 rt_busy"}, {31'b0, b0_rt}, {31'b0, exp_busy(rt, 1'b0)});
        chk({tag, " b0 pend_cnt"}, {26'b0, c0}, popcount());
        chk({tag, " b0 rsv_err"}, {31'b0, e0}, {31'b0, m_err});
        chk({tag, " b1 data_rs"}, d1_rs, exp_data(rs, 1'b1));
        chk({tag, " b1 data_rt"}, d1_rt, exp_data(rt, 1'b1));
        chk({tag, " b1 rs_busy"}, {31'b0, b1_rs}, {31'b0, exp_busy(rs, 1'b1)});
        chk({tag, " b1 rt_busy"}, {31'b0, b1_rt}, {31'b0, exp_busy(rt, 1'b1)});
        chk({tag, " b1 pend_cnt"}, {26'b0, c1}, popcount());
        chk({tag, " b1 rsv_err"}, {31'b0, e1}, {31'b0, m_err});
    endtask

    task automatic idle();
        en = 0; rd = 0; data = 0; rsv_en = 0; rsv_rd = 0; clr = 0;
    endtask

    // Inputs already driven after a falling edge: check, clock, return at next falling edge.
    task automatic cycle(input string tag);
        #1;
        check_all(tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    typedef struct {
        logic        en;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [4:0]  rs, rt;
        logic        rsv_en;
        logic [4:0]  rsv_rd;
        logic        clr;
        logic [31:0] x_rs, x_rt;   // expected BYPASS=0 outputs before the edge
        logic        x_brs, x_brt;
        logic [5:0]  x_cnt;
        logic        x_err;
    } vec_t;

    vec_t vecs [$];

    task automatic add(input logic e, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] a, input logic [4:0] b,
                       input logic re, input logic [4:0] ra, input logic c,
                       input logic [31:0] xa, input logic [31:0] xb,
                       input logic xba, input logic xbb, input logic [5:0] xc, input logic xe);
        vec_t v;
        v.en = e; v.rd = wa; v.data = wd; v.rs = a; v.rt = b;
        v.rsv_en = re; v.rsv_rd = ra; v.clr = c;
        v.x_rs = xa; v.x_rt = xb; v.x_brs = xba; v.x_brt = xbb; v.x_cnt = xc; v.x_err = xe;
        vecs.push_back(v);
    endtask

    initial begin
        // Scoreboard vectors; state entering row 0: regs[i]=0x1000+i for 1..7
        // except regs[5]=0x22, nothing pending.
        //   en rd  data      rs rt rsv rr clr  x_rs      x_rt      brs brt cnt err
        add(0, 0, 32'h0,     4, 0, 1, 4, 0,   32'h1004, 32'h0,    0, 0, 0, 0); // reserve r4
        add(0, 0, 32'h0,     4, 0, 0, 0, 0,   32'h1004, 32'h0,    1, 0, 1, 0); // r4 busy
        add(1, 4, 32'h44,    4, 0, 0, 0, 0,   32'h1004, 32'h0,    1, 0, 1, 0); // write r4
        add(0, 0, 32'h0,     4, 0, 0, 0, 0,   32'h44,   32'h0,    0, 0, 0, 0); // released
        add(0, 0, 32'h0,     4, 0, 1, 4, 0,   32'h44,   32'h0,    0, 0, 0, 0); // reserve r4
        add(0, 0, 32'h0,     4, 0, 1, 4, 0,   32'h44,   32'h0,    1, 0, 1, 0); // again
        add(0, 0, 32'h0,     4, 0, 0, 0, 0,   32'h44,   32'h0,    1, 0, 1, 1); // err pulse
        add(0, 0, 32'h0,     4, 0, 0, 0, 0,   32'h44,   32'h0,    1, 0, 1, 0); // not sticky
        add(0, 0, 32'h0,     6, 0, 1, 6, 0,   32'h1006, 32'h0,    0, 0, 1, 0); // reserve r6
        add(1, 6, 32'h66,    6, 4, 1, 6, 0,   32'h1006, 32'h44,   1, 1, 2, 0); // wr+rsv r6
        add(0, 0, 32'h0,     6, 4, 0, 0, 0,   32'h66,   32'h44,   1, 1, 2, 0); // r6 pending
        add(0, 0, 32'h0,     1, 2, 1, 1, 0,   32'h1001, 32'h1002, 0, 0, 2, 0); // reserve r1
        add(0, 0, 32'h0,     1, 2, 1, 2, 0,   32'h1001, 32'h1002, 1, 0, 3, 0); // reserve r2
        add(0, 0, 32'h0,     1, 2, 1, 3, 0,   32'h1001, 32'h1002, 1, 1, 4, 0); // reserve r3
        add(0, 0, 32'h0,     3, 9, 1, 9, 1,   32'h1003, 32'h0,    1, 0, 5, 0); // clr+rsv r9
        add(0, 0, 32'h0,     9, 4, 0, 0, 0,   32'h0,    32'h44,   0, 0, 0, 0); // flushed

        // Reset held two cycles with a write pending on the inputs.
        model_reset();
        rst = 1; idle(); en = 1; rd = 3; data = 32'hAA; rs = 3; rt = 0;
        #1;
        check_all("reset_held");
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rst = 0; idle(); rs = 3; rt = 3;
        #1;
        chk("reset r3 data_rs", d0_rs, 32'h0);
        chk("reset pend_cnt", {26'b0, c0}, 32'h0);
        chk("reset rs_busy", {31'b0, b0_rs}, 32'h0);
        $display("[TB] reset: data_rs=0x%0h pend_cnt=%0d busy=%0d", d0_rs, c0, b0_rs);
        cycle("post_reset");

        // Write sweep, plus an ignored write to r0.
        for (int i = 1; i <= 7; i++) begin
            idle(); en = 1; rd = 5'(i); data = 32'h1000 + 32'(i); rs = 0; rt = 0;
            cycle("write");
            $display("[TB] write r%0d = 0x%0h", i, 32'h1000 + i);
        end
        idle(); en = 1; rd = 0; data = 32'hDEAD;
        cycle("write_r0");
        for (int i = 0; i <= 7; i++) begin
            idle(); rs = 5'(i); rt = 5'(7 - i);
            #1;
            chk("sweep data_rs", d0_rs, (i == 0) ? 32'h0 : 32'h1000 + 32'(i));
            chk("sweep data_rt", d0_rt, (i == 7) ? 32'h0 : 32'h1000 + 32'(7 - i));
            $display("[TB] read rs=%0d:0x%0h rt=%0d:0x%0h", i, d0_rs, 7 - i, d0_rt);
            cycle("sweep");
        end

        // Read during write of r5: old 0x11, new 0x22.
        idle(); en = 1; rd = 5; data = 32'h11; rs = 5;
        cycle("r5_old");
        idle(); en = 1; rd = 5; data = 32'h22; rs = 5;
        #1;
        chk("rdw bypass0 before edge", d0_rs, 32'h11);
        chk("rdw bypass1 before edge", d1_rs, 32'h22);
        cycle("rdw");
        idle(); rs = 5;
        #1;
        chk("rdw bypass0 after edge", d0_rs, 32'h22);
        chk("rdw bypass1 after edge", d1_rs, 32'h22);
        $display("[TB] read-during-write r5: b0=0x%0h b1=0x%0h", d0_rs, d1_rs);
        cycle("rdw_after");

        // Table-driven scoreboard sequence.
        foreach (vecs[k]) begin
            en = vecs[k].en; rd = vecs[k].rd; data = vecs[k].data;
            rs = vecs[k].rs; rt = vecs[k].rt;
            rsv_en = vecs[k].rsv_en; rsv_rd = vecs[k].rsv_rd; clr = vecs[k].clr;
            #1;
            chk($sformatf("vec%0d data_rs", k), d0_rs, vecs[k].x_rs);
            chk($sformatf("vec%0d data_rt", k), d0_rt, vecs[k].x_rt);
            chk($sformatf("vec%0d rs_busy", k), {31'b0, b0_rs}, {31'b0, vecs[k].x_brs});
            chk($sformatf("vec%0d rt_busy", k), {31'b0, b0_rt}, {31'b0, vecs[k].x_brt});
            chk($sformatf("vec%0d pend_cnt", k), {26'b0, c0}, {26'b0, vecs[k].x_cnt});
            chk($sformatf("vec%0d rsv_err", k), {31'b0, e0}, {31'b0, vecs[k].x_err});
            $display("[TB] vec%0d rs=%0d busy=%0d cnt=%0d err=%0d", k, rs, b0_rs, c0, e0);
            cycle($sformatf("vec%0d", k));
        end

        // Randomised cycles against the reference model, with occasional
        // asynchronous resets asserted mid-cycle.
        for (int n = 0; n < 2000; n++) begin
            int f0 = n_fail;
            en     = ($urandom_range(0, 1) == 1);
            rd     = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            data   = $urandom;
            rs     = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            rt     = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            rsv_en = ($urandom_range(0, 1) == 1);
            rsv_rd = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            clr    = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 199) == 0) begin
                rst = 1;
                model_reset();
            end
            cycle("rand");
            $display("[TB] rand%0d en=%0d rd=%0d rsv=%0d/%0d clr=%0d rst=%0d cnt=%0d %s",
                     n, en, rd, rsv_en, rsv_rd, clr, rst, popcount(),
                     (n_fail == f0) ? "ok" : "bad");
            rst = 0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
